// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the RV32I ALU: resolves MEM/WB forwarding, picks
// operand b, decodes funct3/funct7 into the ALU control code, valid/ready out.
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_imm,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_ctrl,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_illegal
);

    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SLT  = 4'b0001;
    localparam logic [3:0] CTRL_SLTU = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_OR   = 4'b0100;
    localparam logic [3:0] CTRL_AND  = 4'b0111;
    localparam logic [3:0] CTRL_SLL  = 4'b1000;
    localparam logic [3:0] CTRL_SRL  = 4'b1001;
    localparam logic [3:0] CTRL_SRA  = 4'b1010;
    localparam logic [3:0] CTRL_SUB  = 4'b1011;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] next_b;
    logic [3:0]      next_ctrl;
    logic            next_illegal;
    logic            f7_zero;
    logic            f7_alt;

    // MEM is the younger producer, so it beats WB; x0 never forwards.
    function automatic logic [XLEN-1:0] resolve(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   rf_data
    );
        logic [XLEN-1:0] res;
        if (addr == '0)
            res = '0;
        else if (mem_we && (mem_rd == addr) && (mem_rd != '0))
            res = mem_data;
        else if (wb_we && (wb_rd == addr) && (wb_rd != '0))
            res = wb_data;
        else
            res = rf_data;
        return res;
    endfunction

    assign fwd_a   = resolve(rs1_addr, rs1_data);
    assign fwd_b   = resolve(rs2_addr, rs2_data);
    assign next_b  = is_imm ? imm : fwd_b;
    assign f7_zero = (funct7 == 7'h00);
    assign f7_alt  = (funct7 == 7'h20);

    always_comb begin
        next_illegal = 1'b0;
        if (!is_imm) begin
            if (!(f7_zero || f7_alt))
                next_illegal = 1'b1;
            else if (f7_alt && (funct3 != 3'b000) && (funct3 != 3'b101))
                next_illegal = 1'b1;
        end else begin
            if ((funct3 == 3'b001) && !f7_zero)
                next_illegal = 1'b1;
            else if ((funct3 == 3'b101) && !(f7_zero || f7_alt))
                next_illegal = 1'b1;
        end
    end

    always_comb begin
        next_ctrl = CTRL_ADD;
        if (!next_illegal) begin
            unique case (funct3)
                3'b000:  next_ctrl = (!is_imm && funct7[5]) ? CTRL_SUB : CTRL_ADD;
                3'b001:  next_ctrl = CTRL_SLL;
                3'b010:  next_ctrl = CTRL_SLT;
                3'b011:  next_ctrl = CTRL_SLTU;
                3'b100:  next_ctrl = CTRL_XOR;
                3'b101:  next_ctrl = funct7[5] ? CTRL_SRA : CTRL_SRL;
                3'b110:  next_ctrl = CTRL_OR;
                default: next_ctrl = CTRL_AND;
            endcase
        end
    end

    assign in_ready = !flush && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= 4'b0000;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                alu_a       <= fwd_a;
                alu_b       <= next_b;
                alu_ctrl    <= next_ctrl;
                out_rd      <= rd_addr;
                out_illegal <= next_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: forwarding, operand b select, decode,
// illegal detection, backpressure, flush and async reset.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        is_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        mem_we, wb_we;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_data, wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .is_imm(is_imm), .funct3(funct3), .funct7(funct7),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic imm_op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im);
        is_imm = imm_op; funct3 = f3; funct7 = f7;
        rs1_addr = a1; rs2_addr = a2; rd_addr = rd;
        rs1_data = d1; rs2_data = d2; imm = im;
    endtask

    task automatic clear_fwd();
        mem_we = 1'b0; mem_rd = 5'd0; mem_data = 32'h0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    endtask

    task automatic check_entry(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] ctrl, input logic [4:0] rd, input logic ill);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_a"}, alu_a, a);
        check({tag, "_b"}, alu_b, b);
        check({tag, "_ctrl"}, {28'd0, alu_ctrl}, {28'd0, ctrl});
        check({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
        check({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, ill});
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_op(1'b0, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        clear_fwd();
        step(); step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_a", alu_a, 32'd0);
        check("rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // ADD x3,x1,x2
        set_op(1'b0, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0);
        in_valid = 1'b1;
        step();
        check_entry("add", 32'd5, 32'd7, 4'b0000, 5'd3, 1'b0);

        // SUB with both MEM and WB hitting rs1: MEM wins
        set_op(1'b0, 3'b000, 7'h20, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'h0);
        mem_we = 1'b1; mem_rd = 5'd1; mem_data = 32'd100;
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd50;
        step();
        check_entry("sub_fwd", 32'd100, 32'd7, 4'b1011, 5'd4, 1'b0);

        // SRAI from x0 with MEM claiming rd=0: must read zero
        set_op(1'b1, 3'b101, 7'h20, 5'd0, 5'd9, 5'd5, 32'h55, 32'h66, 32'h404);
        clear_fwd();
        mem_we = 1'b1; mem_rd = 5'd0; mem_data = 32'h99;
        step();
        check_entry("srai", 32'd0, 32'h404, 4'b1010, 5'd5, 1'b0);

        // ADDI with imm[10]=1 stays ADD
        set_op(1'b1, 3'b000, 7'h7f, 5'd2, 5'd3, 5'd6, 32'h10, 32'h20, 32'hffff_fc00);
        clear_fwd();
        step();
        check_entry("addi", 32'h10, 32'hffff_fc00, 4'b0000, 5'd6, 1'b0);

        // SLTIU ignores funct7
        set_op(1'b1, 3'b011, 7'h55, 5'd2, 5'd3, 5'd7, 32'h10, 32'h20, 32'h5);
        step();
        check_entry("sltiu", 32'h10, 32'h5, 4'b0010, 5'd7, 1'b0);

        // SRL R-type with rs2 forwarded from WB (MEM writes elsewhere)
        set_op(1'b0, 3'b101, 7'h00, 5'd5, 5'd4, 5'd8, 32'h0f0f, 32'h1, 32'h0);
        mem_we = 1'b1; mem_rd = 5'd6; mem_data = 32'hbeef;
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'hdead;
        step();
        check_entry("srl_wb", 32'h0f0f, 32'hdead, 4'b1001, 5'd8, 1'b0);

        // AND with WB hit but wb_we low: register file value used
        set_op(1'b0, 3'b111, 7'h00, 5'd5, 5'd4, 5'd6, 32'h0f0f, 32'h1234, 32'h0);
        clear_fwd();
        wb_rd = 5'd4; wb_data = 32'hdead;
        step();
        check_entry("and", 32'h0f0f, 32'h1234, 4'b0111, 5'd6, 1'b0);

        // Backpressure: hold AND entry for 3 cycles while XOR is offered
        out_ready = 1'b0;
        set_op(1'b0, 3'b100, 7'h00, 5'd7, 5'd8, 5'd9, 32'h11, 32'h22, 32'h0);
        #1;
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_entry("bp_hold", 32'h0f0f, 32'h1234, 4'b0111, 5'd6, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_entry("xor", 32'h11, 32'h22, 4'b0011, 5'd9, 1'b0);

        // Flush wins over a valid offer
        flush = 1'b1;
        set_op(1'b0, 3'b110, 7'h00, 5'd10, 5'd11, 5'd10, 32'h33, 32'h44, 32'h0);
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_no_capture", alu_a, 32'h11);
        flush = 1'b0;
        step();
        check_entry("or", 32'h33, 32'h44, 4'b0100, 5'd10, 1'b0);

        // Drain: consumer takes entry, nothing new offered
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Illegal encodings
        in_valid = 1'b1;
        set_op(1'b0, 3'b000, 7'h01, 5'd1, 5'd2, 5'd11, 32'h1, 32'h2, 32'h0);
        step();
        check_entry("mul_ill", 32'h1, 32'h2, 4'b0000, 5'd11, 1'b1);
        set_op(1'b1, 3'b001, 7'h20, 5'd1, 5'd2, 5'd12, 32'h1, 32'h2, 32'h3);
        step();
        check_entry("slli_ill", 32'h1, 32'h3, 4'b0000, 5'd12, 1'b1);
        set_op(1'b0, 3'b100, 7'h20, 5'd1, 5'd2, 5'd13, 32'h1, 32'h2, 32'h0);
        step();
        check_entry("xor20_ill", 32'h1, 32'h2, 4'b0000, 5'd13, 1'b1);

        // Hold, then async reset mid-cycle
        out_ready = 1'b0;
        in_valid = 1'b0;
        step();
        check_entry("ill_hold", 32'h1, 32'h2, 4'b0000, 5'd13, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", {31'd0, out_valid}, 32'd0);
        check("areset_a", alu_a, 32'd0);
        check("areset_b", alu_b, 32'd0);
        check("areset_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("areset_rd", {27'd0, out_rd}, 32'd0);
        check("areset_ill", {31'd0, out_illegal}, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
